// File: rtl/c_incr_wrap_if.sv
// Bundles the incrementer's data and counter signals; master drives inputs, slave is the block.
interface c_incr_wrap_if #(
  parameter int unsigned Width = 4
);
  logic [Width-1:0] data_in;
  logic [Width-1:0] data_out;
  logic             wrap;
  logic             range_err;
  logic             advance;
  logic [Width-1:0] count_out;
  logic             count_wrap;

  modport master (
    output data_in,
    output advance,
    input  data_out,
    input  wrap,
    input  range_err,
    input  count_out,
    input  count_wrap
  );

  modport slave (
    input  data_in,
    input  advance,
    output data_out,
    output wrap,
    output range_err,
    output count_out,
    output count_wrap
  );
endinterface

// File: rtl/c_incr_wrap.sv
// Wrap-around modulo incrementer over [MinValue, MaxValue], with a registered counter
// stepping through the same sequence.
module c_incr_wrap #(
  parameter int unsigned Width    = 4,
  parameter int unsigned MinValue = 4,
  parameter int unsigned MaxValue = 7
) (
  input logic          clk,
  input logic          reset,
  c_incr_wrap_if.slave bus
);

  if (Width < 1 || Width > 31 || MinValue > MaxValue || MaxValue > (2 ** Width) - 1) begin : g_bad
    $error("c_incr_wrap: need 0 <= MinValue <= MaxValue <= 2**Width-1");
  end

  localparam int               MinI = int'(MinValue);
  localparam int               MaxI = int'(MaxValue);
  localparam logic [Width-1:0] MinV = Width'(MinValue);

  // Compared as int so a zero MinValue or full-scale MaxValue never yields a constant compare.
  function automatic logic out_of_range(input logic [Width-1:0] v);
    return (int'(32'(v)) < MinI) || (int'(32'(v)) > MaxI);
  endfunction

  function automatic logic at_max(input logic [Width-1:0] v);
    return int'(32'(v)) == MaxI;
  endfunction

  // Max is tested before the +1, so the addition can never overflow.
  function automatic logic [Width-1:0] succ(input logic [Width-1:0] v);
    logic [Width-1:0] r;
    if (out_of_range(v) || at_max(v)) begin
      r = MinV;
    end else begin
      r = v + Width'(1);
    end
    return r;
  endfunction

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    bus.data_out  = succ(bus.data_in);
    bus.range_err = out_of_range(bus.data_in);
    bus.wrap      = at_max(bus.data_in);
  end

  always_comb begin
    count_d = count_q;
    if (bus.advance) begin
      count_d = succ(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MinV;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count_out  = count_q;
  assign bus.count_wrap = at_max(count_q);

endmodule

// File: tb/tb_c_incr_wrap.sv
// Directed-vector bench for c_incr_wrap: default range, full range and single-value range.
module tb_c_incr_wrap;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  c_incr_wrap_if #(.Width(4)) bus_d ();
  c_incr_wrap_if #(.Width(4)) bus_f ();
  c_incr_wrap_if #(.Width(3)) bus_s ();

  c_incr_wrap #(.Width(4), .MinValue(4), .MaxValue(7)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d)
  );

  c_incr_wrap #(.Width(4), .MinValue(0), .MaxValue(15)) u_full (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  c_incr_wrap #(.Width(3), .MinValue(2), .MaxValue(2)) u_single (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned din_a  [4] = '{4, 5, 6, 7};
  int unsigned dout_a [4] = '{5, 6, 7, 4};
  int unsigned bad_a  [4] = '{0, 3, 8, 15};
  int unsigned cnt3   [5] = '{5, 6, 7, 4, 5};
  logic        adv4   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int unsigned cnt4   [4] = '{5, 5, 6, 6};

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus_d.data_in = '0;
    bus_d.advance = 1'b0;
    bus_f.data_in = '0;
    bus_f.advance = 1'b0;
    bus_s.data_in = '0;
    bus_s.advance = 1'b0;

    // In-range inputs
    foreach (din_a[i]) begin
      bus_d.data_in = 4'(din_a[i]);
      #1;
      check_eq($sformatf("dout_%0d", din_a[i]), bus_d.data_out, dout_a[i]);
      check_eq($sformatf("wrap_%0d", din_a[i]), bus_d.wrap, (din_a[i] == 7) ? 1 : 0);
      check_eq($sformatf("rerr_%0d", din_a[i]), bus_d.range_err, 0);
    end

    // Out-of-range inputs recover to range start
    foreach (bad_a[i]) begin
      bus_d.data_in = 4'(bad_a[i]);
      #1;
      check_eq($sformatf("oor_dout_%0d", bad_a[i]), bus_d.data_out, 4);
      check_eq($sformatf("oor_rerr_%0d", bad_a[i]), bus_d.range_err, 1);
      check_eq($sformatf("oor_wrap_%0d", bad_a[i]), bus_d.wrap, 0);
    end

    // Counter: reset then advance held high
    reset = 1'b1;
    bus_d.data_in = 4'd5;
    tick();
    check_eq("rst_count", bus_d.count_out, 4);
    check_eq("rst_cwrap", bus_d.count_wrap, 0);
    check_eq("rst_comb_dout", bus_d.data_out, 6);
    check_eq("rst_full_count", bus_f.count_out, 0);
    check_eq("rst_single_count", bus_s.count_out, 2);
    reset = 1'b0;
    bus_d.advance = 1'b1;
    foreach (cnt3[i]) begin
      tick();
      check_eq($sformatf("adv_count_%0d", i), bus_d.count_out, cnt3[i]);
      check_eq($sformatf("adv_cwrap_%0d", i), bus_d.count_wrap, (cnt3[i] == 7) ? 1 : 0);
    end

    // Counter holds when advance is low
    reset = 1'b1;
    bus_d.advance = 1'b0;
    tick();
    reset = 1'b0;
    foreach (adv4[i]) begin
      bus_d.advance = adv4[i];
      tick();
      check_eq($sformatf("tog_count_%0d", i), bus_d.count_out, cnt4[i]);
    end

    // Reset has priority over advance mid-sequence
    reset = 1'b1;
    bus_d.advance = 1'b0;
    tick();
    reset = 1'b0;
    bus_d.advance = 1'b1;
    tick();
    tick();
    check_eq("pri_pre_count", bus_d.count_out, 6);
    reset = 1'b1;
    tick();
    check_eq("pri_count", bus_d.count_out, 4);
    reset = 1'b0;
    bus_d.advance = 1'b0;

    // Full range: natural rollover
    bus_f.data_in = 4'd14;
    #1;
    check_eq("full_dout_14", bus_f.data_out, 15);
    check_eq("full_wrap_14", bus_f.wrap, 0);
    bus_f.data_in = 4'd15;
    #1;
    check_eq("full_dout_15", bus_f.data_out, 0);
    check_eq("full_wrap_15", bus_f.wrap, 1);
    check_eq("full_rerr_15", bus_f.range_err, 0);

    // Single-value range
    bus_s.data_in = 3'd2;
    #1;
    check_eq("single_dout_2", bus_s.data_out, 2);
    check_eq("single_wrap_2", bus_s.wrap, 1);
    check_eq("single_rerr_2", bus_s.range_err, 0);
    bus_s.data_in = 3'd3;
    #1;
    check_eq("single_dout_3", bus_s.data_out, 2);
    check_eq("single_rerr_3", bus_s.range_err, 1);
    check_eq("single_wrap_3", bus_s.wrap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
